arm_isa_frontend: RTL and testbench
===================================

# arm_isa_frontend

ARM-side front end of the PC104 ISA bridge in the CPLD. It synchronises the ARM static-memory strobes and builds a 23-bit ISA address from a local page register plus the 12 ARM address lines. Each ARM access becomes one request/response transaction to the downstream ISA cycle engine. It holds the ARM through `arm_wait` until the transaction completes or times out.

## Interface
- `SYNC_STAGES`, 2: flip-flop depth of the strobe synchronisers (≥2).
- `TIMEOUT_CYC`, 1023: clk cycles allowed in WAIT_RSP before abort (1..65535).
- `clk  in  1` system clock, 50 MHz.
- `rst  in  1` reset. Synchronous, active-high; one clock; reset is synchronous and active-high.
- `arm_cs  in  1` chip select, active low, async to clk.
- `arm_rd` / `arm_wr  in  1` each: read / write strobe, active low, async.
- `addr_sel  in  1` 1 = ISA window access, 0 = page-register access, async.
- `arm_addr  in  12` ARM address lines.
- `arm_data_in  in  16` ARM write data.
- `arm_data_out  out  16` read data to the ARM.
- `arm_data_oe  out  1` 1 = drive `arm_data_out` onto the ARM bus.
- `arm_wait  out  1` 1 = ready, 0 = stall the ARM.
- `req_valid  out  1`, `req_ready  in  1`: request handshake to the ISA cycle engine.
- `req_write  out  1` 1 = ISA memory write, 0 = read.
- `req_addr  out  23` {page[10:0], arm_addr[11:0]}.
- `req_wdata  out  16` write data.
- `rsp_valid  in  1`, `rsp_rdata  in  16`: one-cycle completion pulse, with read data.
- `clr_err  in  1` clears `timeout_err`.
- `timeout_err  out  1` sticky flag: timeout or protocol error.
- `busy  out  1` state ≠ IDLE.

## Operation
- `arm_cs`, `arm_rd`, `arm_wr` and `addr_sel` each pass through a SYNC_STAGES synchroniser.
- A falling edge on synced `arm_cs` in IDLE moves to DECODE.
- `arm_addr` and `arm_data_in` are sampled unsynchronised in DECODE. The ARM timing set-up guarantees they are stable from `arm_cs` fall to `arm_cs` rise.
- DECODE, by synced strobes:
  - rd=wr=0: protocol error. Set `timeout_err`, return `arm_data_out`=16'hFFFF, go to DONE.
  - rd=wr=1: no-op, go to DONE.
  - addr_sel=0, write: page ← arm_addr[10:0], go to DONE.
  - addr_sel=0, read: `arm_data_out` ← {5'b0, page}, go to DONE.
  - addr_sel=1: load req_addr, req_write and req_wdata, go to REQ.
- REQ: `req_valid`=1, with req_* held stable until `req_ready`. On `req_valid & req_ready`, go to WAIT_RSP and clear the timeout counter.
- WAIT_RSP:
  - On `rsp_valid`: for a read, `arm_data_out` ← `rsp_rdata`. Go to DONE.
  - On counter = TIMEOUT_CYC-1 with no response: `arm_data_out` ← 16'hFFFF, set `timeout_err`, go to DONE.
  - A `rsp_valid` arriving in any other state is ignored.
- DONE: stay until synced `arm_cs`=1, then go to IDLE.
- `arm_data_oe` = 1 in DONE for read accesses only.
- `arm_wait` = 0 whenever raw `arm_cs`=0 and state ≠ DONE, otherwise 1. This is combinational from the pin so the ARM sees the stall before the synchroniser latency elapses.
- If `arm_cs` rises before DONE:
  - In REQ, `req_valid` is never dropped before acceptance.
  - The transaction runs to completion or timeout, its data is discarded, and the block goes straight to IDLE.
- `clr_err` and a new error in the same cycle: the set wins.

## Timing
- Reset values:
  - `req_valid` 0, `req_write` 0, `req_addr` 0, `req_wdata` 0.
  - page 0, `arm_data_out` 0, `arm_data_oe` 0.
  - `arm_wait` 1 (while `arm_cs`=1), `timeout_err` 0, `busy` 0, state IDLE.
- Reset mid-transaction returns to IDLE in one cycle. An outstanding response is not waited for.
- Let E be the cycle in which synced `arm_cs` is first seen low:
  - DECODE at E+1.
  - `req_valid` high at E+2.
  - A page access reaches DONE at E+2.
- `rsp_valid` in cycle R gives DONE at R+1, with `arm_wait` and `arm_data_oe` changing at R+1.
- Timeout: exactly TIMEOUT_CYC cycles in WAIT_RSP before DONE.
- Back-to-back accesses need synced `arm_cs` high for ≥1 cycle, which passes through IDLE.

## Structure
- Package `arm_isa_pkg` holds:
  - state enum {IDLE, DECODE, REQ, WAIT_RSP, DONE};
  - `ADDR_W`=23, `PAGE_W`=11, `DATA_W`=16;
  - `ERR_DATA`=16'hFFFF.
- Sub-module `bus_sync`: a SYNC_STAGES flip-flop chain with a synchronous reset value parameter. `arm_cs`, `arm_rd` and `arm_wr` reset to 1; `addr_sel` resets to 0.
- The FSM, page register, timeout counter and data registers live in the top level.

## Test plan
- Page write addr_sel=0, arm_addr=12'h5A3, then an ISA read at arm_addr=12'h010 with rsp_rdata=16'hBEEF after 5 cycles -> req_addr=23'h5A3010, arm_data_out=16'hBEEF with oe=1, then oe=0 after cs rises.
- ISA write with data 16'h1234 and req_ready held low for 4 cycles -> req_valid stays 1 with stable req_* for those 4 cycles, and arm_wait stays 0 until the cycle after rsp_valid.
- No response with TIMEOUT_CYC=8 -> DONE after exactly 8 WAIT_RSP cycles, read data 16'hFFFF, timeout_err=1. Then a clr_err pulse -> timeout_err=0.
- arm_rd and arm_wr both low -> no request issued, timeout_err=1, DONE reached at E+2.
- arm_cs released during REQ -> request is still accepted and completed, the response is discarded, state goes to IDLE, arm_data_oe never asserts.
- rst asserted in WAIT_RSP -> the next cycle shows all outputs at reset values and page=0. A late rsp_valid afterwards is ignored.

Source files
------------

// File: rtl/arm_isa_pkg.sv
// Shared types and constants for the ARM-side front end of the PC104 ISA bridge.
package arm_isa_pkg;

   localparam int unsigned ADDR_W     = 23;
   localparam int unsigned PAGE_W     = 11;
   localparam int unsigned DATA_W     = 16;
   localparam int unsigned ARM_ADDR_W = 12;

   localparam logic [DATA_W-1:0] ERR_DATA = 16'hFFFF;

   typedef enum logic [2:0] {
      StIdle,
      StDecode,
      StReq,
      StWaitRsp,
      StDone
   } state_e;

endpackage

// File: rtl/bus_sync.sv
// Single-bit flip-flop chain synchroniser with a configurable synchronous reset value.
module bus_sync #(
   parameter int unsigned Stages   = 2,
   parameter logic        ResetVal = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [Stages-1:0] sync_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= {Stages{ResetVal}};
      end else begin
         sync_q <= {sync_q[Stages-2:0], d};
      end
   end

   assign q = sync_q[Stages-1];

endmodule

// File: rtl/arm_isa_frontend.sv
// ARM static-memory front end: turns each ARM access into one ISA request/response
// transaction, or serves it locally from the page register.
module arm_isa_frontend
   import arm_isa_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned TIMEOUT_CYC = 1023
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  arm_cs,
   input  logic                  arm_rd,
   input  logic                  arm_wr,
   input  logic                  addr_sel,
   input  logic [ARM_ADDR_W-1:0] arm_addr,
   input  logic [DATA_W-1:0]     arm_data_in,
   output logic [DATA_W-1:0]     arm_data_out,
   output logic                  arm_data_oe,
   output logic                  arm_wait,
   output logic                  req_valid,
   input  logic                  req_ready,
   output logic                  req_write,
   output logic [ADDR_W-1:0]     req_addr,
   output logic [DATA_W-1:0]     req_wdata,
   input  logic                  rsp_valid,
   input  logic [DATA_W-1:0]     rsp_rdata,
   input  logic                  clr_err,
   output logic                  timeout_err,
   output logic                  busy
);

   localparam logic [15:0] CntLast = 16'(TIMEOUT_CYC - 1);

   logic cs_s, rd_s, wr_s, sel_s;

   bus_sync #(.Stages(SYNC_STAGES), .ResetVal(1'b1)) u_sync_cs (
      .clk (clk),
      .rst (rst),
      .d   (arm_cs),
      .q   (cs_s)
   );

   bus_sync #(.Stages(SYNC_STAGES), .ResetVal(1'b1)) u_sync_rd (
      .clk (clk),
      .rst (rst),
      .d   (arm_rd),
      .q   (rd_s)
   );

   bus_sync #(.Stages(SYNC_STAGES), .ResetVal(1'b1)) u_sync_wr (
      .clk (clk),
      .rst (rst),
      .d   (arm_wr),
      .q   (wr_s)
   );

   bus_sync #(.Stages(SYNC_STAGES), .ResetVal(1'b0)) u_sync_sel (
      .clk (clk),
      .rst (rst),
      .d   (addr_sel),
      .q   (sel_s)
   );

   state_e              state_q, state_d;
   logic                cs_prev_q;
   logic [PAGE_W-1:0]   page_q, page_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                req_valid_q, req_valid_d;
   logic                req_write_q, req_write_d;
   logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
   logic [DATA_W-1:0]   req_wdata_q, req_wdata_d;
   logic [15:0]         cnt_q, cnt_d;
   logic                err_q, err_d, err_set;
   logic                rd_acc_q, rd_acc_d;
   logic                abort_q, abort_d;
   logic                abort_now;

   // ARM gave up on the access: finish the ISA transaction but drop its result.
   assign abort_now = abort_q | cs_s;

   always_comb begin
      state_d     = state_q;
      page_d      = page_q;
      rdata_d     = rdata_q;
      req_valid_d = req_valid_q;
      req_write_d = req_write_q;
      req_addr_d  = req_addr_q;
      req_wdata_d = req_wdata_q;
      cnt_d       = cnt_q;
      err_set     = 1'b0;
      rd_acc_d    = rd_acc_q;
      abort_d     = abort_q;

      unique case (state_q)
         StIdle: begin
            abort_d = 1'b0;
            if (cs_prev_q && !cs_s) begin
               state_d = StDecode;
            end
         end

         StDecode: begin
            rd_acc_d = !rd_s;
            abort_d  = cs_s;
            state_d  = StDone;
            if (!rd_s && !wr_s) begin
               err_set = 1'b1;
               rdata_d = ERR_DATA;
            end else if (rd_s && wr_s) begin
               state_d = StDone;
            end else if (!sel_s) begin
               if (!wr_s) begin
                  page_d = arm_addr[PAGE_W-1:0];
               end else begin
                  rdata_d = {{(DATA_W-PAGE_W){1'b0}}, page_q};
               end
            end else begin
               req_valid_d = 1'b1;
               req_write_d = !wr_s;
               req_addr_d  = {page_q, arm_addr};
               req_wdata_d = arm_data_in;
               state_d     = StReq;
            end
         end

         StReq: begin
            abort_d = abort_now;
            if (req_ready) begin
               req_valid_d = 1'b0;
               cnt_d       = '0;
               state_d     = StWaitRsp;
            end
         end

         StWaitRsp: begin
            abort_d = abort_now;
            if (rsp_valid) begin
               if (abort_now) begin
                  state_d = StIdle;
               end else begin
                  if (rd_acc_q) begin
                     rdata_d = rsp_rdata;
                  end
                  state_d = StDone;
               end
            end else if (cnt_q == CntLast) begin
               err_set = 1'b1;
               if (abort_now) begin
                  state_d = StIdle;
               end else begin
                  rdata_d = ERR_DATA;
                  state_d = StDone;
               end
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end

         StDone: begin
            if (cs_s) begin
               state_d = StIdle;
            end
         end

         default: state_d = StIdle;
      endcase
   end

   // A new error in the same cycle as clr_err wins.
   always_comb begin
      err_d = err_q;
      if (clr_err) begin
         err_d = 1'b0;
      end
      if (err_set) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         cs_prev_q   <= 1'b1;
         page_q      <= '0;
         rdata_q     <= '0;
         req_valid_q <= 1'b0;
         req_write_q <= 1'b0;
         req_addr_q  <= '0;
         req_wdata_q <= '0;
         cnt_q       <= '0;
         err_q       <= 1'b0;
         rd_acc_q    <= 1'b0;
         abort_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cs_prev_q   <= cs_s;
         page_q      <= page_d;
         rdata_q     <= rdata_d;
         req_valid_q <= req_valid_d;
         req_write_q <= req_write_d;
         req_addr_q  <= req_addr_d;
         req_wdata_q <= req_wdata_d;
         cnt_q       <= cnt_d;
         err_q       <= err_d;
         rd_acc_q    <= rd_acc_d;
         abort_q     <= abort_d;
      end
   end

   // Stall straight from the pin so the ARM is held before the synchronisers catch up.
   assign arm_wait     = !(!arm_cs && (state_q != StDone));
   assign arm_data_oe  = (state_q == StDone) && rd_acc_q;
   assign arm_data_out = rdata_q;
   assign busy         = (state_q != StIdle);
   assign timeout_err  = err_q;
   assign req_valid    = req_valid_q;
   assign req_write    = req_write_q;
   assign req_addr     = req_addr_q;
   assign req_wdata    = req_wdata_q;

endmodule

// File: tb/tb_arm_isa_frontend.sv
// Directed self-checking bench for arm_isa_frontend (TIMEOUT_CYC = 8).
module tb_arm_isa_frontend;

   logic        clk = 1'b0;
   logic        rst;
   logic        arm_cs, arm_rd, arm_wr, addr_sel;
   logic [11:0] arm_addr;
   logic [15:0] arm_data_in;
   logic [15:0] arm_data_out;
   logic        arm_data_oe, arm_wait;
   logic        req_valid, req_ready, req_write;
   logic [22:0] req_addr;
   logic [15:0] req_wdata;
   logic        rsp_valid;
   logic [15:0] rsp_rdata;
   logic        clr_err, timeout_err, busy;

   int n_cmp = 0;
   int n_err = 0;

   always #10 clk = ~clk;

   arm_isa_frontend #(.SYNC_STAGES(2), .TIMEOUT_CYC(8)) dut (
      .clk          (clk),
      .rst          (rst),
      .arm_cs       (arm_cs),
      .arm_rd       (arm_rd),
      .arm_wr       (arm_wr),
      .addr_sel     (addr_sel),
      .arm_addr     (arm_addr),
      .arm_data_in  (arm_data_in),
      .arm_data_out (arm_data_out),
      .arm_data_oe  (arm_data_oe),
      .arm_wait     (arm_wait),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_write    (req_write),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .rsp_valid    (rsp_valid),
      .rsp_rdata    (rsp_rdata),
      .clr_err      (clr_err),
      .timeout_err  (timeout_err),
      .busy         (busy)
   );

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; arm_cs = 1'b1; arm_rd = 1'b1; arm_wr = 1'b1; addr_sel = 1'b0;
      arm_addr = '0; arm_data_in = '0; req_ready = 1'b0; rsp_valid = 1'b0;
      rsp_rdata = '0; clr_err = 1'b0;
      tick(3);
      rst = 1'b0;
      tick(1);
      n_cmp++; if (req_valid !== 1'b0) begin n_err++; $display("FAIL rst_req_valid: got %b want 0", req_valid); end
      n_cmp++; if (req_write !== 1'b0) begin n_err++; $display("FAIL rst_req_write: got %b want 0", req_write); end
      n_cmp++; if (req_addr !== 23'h0) begin n_err++; $display("FAIL rst_req_addr: got %h want 0", req_addr); end
      n_cmp++; if (req_wdata !== 16'h0) begin n_err++; $display("FAIL rst_req_wdata: got %h want 0", req_wdata); end
      n_cmp++; if (arm_data_out !== 16'h0) begin n_err++; $display("FAIL rst_data: got %h want 0", arm_data_out); end
      n_cmp++; if (arm_data_oe !== 1'b0) begin n_err++; $display("FAIL rst_oe: got %b want 0", arm_data_oe); end
      n_cmp++; if (arm_wait !== 1'b1) begin n_err++; $display("FAIL rst_wait: got %b want 1", arm_wait); end
      n_cmp++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL rst_err: got %b want 0", timeout_err); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
   endtask

   task automatic test_page_then_read;
      arm_cs = 1'b0; arm_wr = 1'b0; addr_sel = 1'b0; arm_addr = 12'h5A3;
      tick(3);
      n_cmp++; if (arm_wait !== 1'b0) begin n_err++; $display("FAIL pg_wr_stall: got %b want 0", arm_wait); end
      tick(1);
      n_cmp++; if (arm_wait !== 1'b1) begin n_err++; $display("FAIL pg_wr_done: got %b want 1", arm_wait); end
      n_cmp++; if (arm_data_oe !== 1'b0) begin n_err++; $display("FAIL pg_wr_oe: got %b want 0", arm_data_oe); end
      arm_cs = 1'b1; arm_wr = 1'b1;
      tick(3);
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL pg_wr_idle: got %b want 0", busy); end
      arm_cs = 1'b0; arm_rd = 1'b0; addr_sel = 1'b1; arm_addr = 12'h010;
      tick(3);
      n_cmp++; if (req_valid !== 1'b0) begin n_err++; $display("FAIL rd_decode_valid: got %b want 0", req_valid); end
      tick(1);
      n_cmp++; if (req_valid !== 1'b1) begin n_err++; $display("FAIL rd_req_valid: got %b want 1", req_valid); end
      n_cmp++; if (req_addr !== 23'h5A3010) begin n_err++; $display("FAIL rd_req_addr: got %h want 5a3010", req_addr); end
      n_cmp++; if (req_write !== 1'b0) begin n_err++; $display("FAIL rd_req_write: got %b want 0", req_write); end
      req_ready = 1'b1;
      tick(1);
      req_ready = 1'b0;
      n_cmp++; if (req_valid !== 1'b0) begin n_err++; $display("FAIL rd_accept: got %b want 0", req_valid); end
      tick(4);
      rsp_valid = 1'b1; rsp_rdata = 16'hBEEF;
      n_cmp++; if (arm_wait !== 1'b0) begin n_err++; $display("FAIL rd_wait_rsp: got %b want 0", arm_wait); end
      tick(1);
      rsp_valid = 1'b0;
      n_cmp++; if (arm_wait !== 1'b1) begin n_err++; $display("FAIL rd_done_wait: got %b want 1", arm_wait); end
      n_cmp++; if (arm_data_oe !== 1'b1) begin n_err++; $display("FAIL rd_done_oe: got %b want 1", arm_data_oe); end
      n_cmp++; if (arm_data_out !== 16'hBEEF) begin n_err++; $display("FAIL rd_data: got %h want beef", arm_data_out); end
      arm_cs = 1'b1; arm_rd = 1'b1;
      tick(2);
      n_cmp++; if (arm_data_oe !== 1'b1) begin n_err++; $display("FAIL rd_oe_hold: got %b want 1", arm_data_oe); end
      tick(1);
      n_cmp++; if (arm_data_oe !== 1'b0) begin n_err++; $display("FAIL rd_oe_release: got %b want 0", arm_data_oe); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rd_idle: got %b want 0", busy); end
   endtask

   task automatic test_write_stall;
      arm_cs = 1'b0; arm_wr = 1'b0; addr_sel = 1'b1; arm_addr = 12'h020; arm_data_in = 16'h1234;
      tick(4);
      for (int i = 0; i < 4; i++) begin
         n_cmp++; if (req_valid !== 1'b1) begin n_err++; $display("FAIL wr_hold_valid[%0d]: got %b want 1", i, req_valid); end
         n_cmp++; if (req_addr !== 23'h5A3020) begin n_err++; $display("FAIL wr_hold_addr[%0d]: got %h want 5a3020", i, req_addr); end
         n_cmp++; if (req_wdata !== 16'h1234) begin n_err++; $display("FAIL wr_hold_wdata[%0d]: got %h want 1234", i, req_wdata); end
         n_cmp++; if (req_write !== 1'b1) begin n_err++; $display("FAIL wr_hold_write[%0d]: got %b want 1", i, req_write); end
         n_cmp++; if (arm_wait !== 1'b0) begin n_err++; $display("FAIL wr_hold_wait[%0d]: got %b want 0", i, arm_wait); end
         tick(1);
      end
      req_ready = 1'b1;
      tick(1);
      req_ready = 1'b0;
      n_cmp++; if (req_valid !== 1'b0) begin n_err++; $display("FAIL wr_accept: got %b want 0", req_valid); end
      tick(2);
      rsp_valid = 1'b1; rsp_rdata = 16'hAAAA;
      n_cmp++; if (arm_wait !== 1'b0) begin n_err++; $display("FAIL wr_wait_rsp: got %b want 0", arm_wait); end
      tick(1);
      rsp_valid = 1'b0;
      n_cmp++; if (arm_wait !== 1'b1) begin n_err++; $display("FAIL wr_done_wait: got %b want 1", arm_wait); end
      n_cmp++; if (arm_data_oe !== 1'b0) begin n_err++; $display("FAIL wr_done_oe: got %b want 0", arm_data_oe); end
      n_cmp++; if (arm_data_out !== 16'hBEEF) begin n_err++; $display("FAIL wr_data_kept: got %h want beef", arm_data_out); end
      arm_cs = 1'b1; arm_wr = 1'b1;
      tick(3);
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL wr_idle: got %b want 0", busy); end
   endtask

   task automatic test_abort;
      arm_cs = 1'b0; arm_rd = 1'b0; addr_sel = 1'b1; arm_addr = 12'h040;
      tick(4);
      n_cmp++; if (req_addr !== 23'h5A3040) begin n_err++; $display("FAIL ab_req_addr: got %h want 5a3040", req_addr); end
      arm_cs = 1'b1; arm_rd = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick(1);
         n_cmp++; if (req_valid !== 1'b1) begin n_err++; $display("FAIL ab_valid_held[%0d]: got %b want 1", i, req_valid); end
         n_cmp++; if (arm_data_oe !== 1'b0) begin n_err++; $display("FAIL ab_oe[%0d]: got %b want 0", i, arm_data_oe); end
      end
      req_ready = 1'b1;
      tick(1);
      req_ready = 1'b0;
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL ab_busy: got %b want 1", busy); end
      tick(1);
      rsp_valid = 1'b1; rsp_rdata = 16'h1111;
      tick(1);
      rsp_valid = 1'b0;
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL ab_idle: got %b want 0", busy); end
      n_cmp++; if (arm_data_oe !== 1'b0) begin n_err++; $display("FAIL ab_oe_end: got %b want 0", arm_data_oe); end
      n_cmp++; if (arm_data_out !== 16'hBEEF) begin n_err++; $display("FAIL ab_discard: got %h want beef", arm_data_out); end
   endtask

   task automatic test_timeout;
      arm_cs = 1'b0; arm_rd = 1'b0; addr_sel = 1'b1; arm_addr = 12'h030;
      tick(4);
      req_ready = 1'b1;
      tick(1);
      req_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         n_cmp++; if (arm_wait !== 1'b0) begin n_err++; $display("FAIL to_wait[%0d]: got %b want 0", i, arm_wait); end
         tick(1);
      end
      n_cmp++; if (arm_wait !== 1'b1) begin n_err++; $display("FAIL to_done: got %b want 1", arm_wait); end
      n_cmp++; if (arm_data_out !== 16'hFFFF) begin n_err++; $display("FAIL to_data: got %h want ffff", arm_data_out); end
      n_cmp++; if (arm_data_oe !== 1'b1) begin n_err++; $display("FAIL to_oe: got %b want 1", arm_data_oe); end
      n_cmp++; if (timeout_err !== 1'b1) begin n_err++; $display("FAIL to_err: got %b want 1", timeout_err); end
      arm_cs = 1'b1; arm_rd = 1'b1;
      tick(3);
      clr_err = 1'b1;
      tick(1);
      clr_err = 1'b0;
      n_cmp++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL to_clr: got %b want 0", timeout_err); end
   endtask

   task automatic test_proto_err;
      // Page read first so the error data is a visible change.
      arm_cs = 1'b0; arm_rd = 1'b0; addr_sel = 1'b0;
      tick(4);
      n_cmp++; if (arm_data_out !== 16'h05A3) begin n_err++; $display("FAIL pg_rd_data: got %h want 05a3", arm_data_out); end
      arm_cs = 1'b1; arm_rd = 1'b1;
      tick(3);
      arm_cs = 1'b0; arm_rd = 1'b0; arm_wr = 1'b0; addr_sel = 1'b1;
      tick(3);
      n_cmp++; if (arm_wait !== 1'b0) begin n_err++; $display("FAIL pe_stall: got %b want 0", arm_wait); end
      tick(1);
      n_cmp++; if (arm_wait !== 1'b1) begin n_err++; $display("FAIL pe_done: got %b want 1", arm_wait); end
      n_cmp++; if (req_valid !== 1'b0) begin n_err++; $display("FAIL pe_no_req: got %b want 0", req_valid); end
      n_cmp++; if (timeout_err !== 1'b1) begin n_err++; $display("FAIL pe_err: got %b want 1", timeout_err); end
      n_cmp++; if (arm_data_out !== 16'hFFFF) begin n_err++; $display("FAIL pe_data: got %h want ffff", arm_data_out); end
      arm_cs = 1'b1; arm_rd = 1'b1; arm_wr = 1'b1;
      tick(3);
      clr_err = 1'b1;
      tick(1);
      clr_err = 1'b0;
   endtask

   task automatic test_reset_mid;
      arm_cs = 1'b0; arm_rd = 1'b0; addr_sel = 1'b1; arm_addr = 12'h050;
      tick(4);
      req_ready = 1'b1;
      tick(1);
      req_ready = 1'b0;
      tick(2);
      rst = 1'b1; arm_cs = 1'b1; arm_rd = 1'b1;
      tick(1);
      rst = 1'b0;
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rm_busy: got %b want 0", busy); end
      n_cmp++; if (req_addr !== 23'h0) begin n_err++; $display("FAIL rm_req_addr: got %h want 0", req_addr); end
      n_cmp++; if (req_valid !== 1'b0) begin n_err++; $display("FAIL rm_req_valid: got %b want 0", req_valid); end
      n_cmp++; if (arm_data_out !== 16'h0) begin n_err++; $display("FAIL rm_data: got %h want 0", arm_data_out); end
      n_cmp++; if (arm_wait !== 1'b1) begin n_err++; $display("FAIL rm_wait: got %b want 1", arm_wait); end
      rsp_valid = 1'b1; rsp_rdata = 16'h7777;
      tick(1);
      rsp_valid = 1'b0;
      tick(1);
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rm_late_rsp_busy: got %b want 0", busy); end
      n_cmp++; if (arm_data_out !== 16'h0) begin n_err++; $display("FAIL rm_late_rsp_data: got %h want 0", arm_data_out); end
      // Page must be back to zero: upper address bits of the next request are clear.
      arm_cs = 1'b0; arm_rd = 1'b0; addr_sel = 1'b1; arm_addr = 12'h060;
      tick(4);
      n_cmp++; if (req_addr !== 23'h000060) begin n_err++; $display("FAIL rm_page_zero: got %h want 000060", req_addr); end
      req_ready = 1'b1;
      tick(1);
      req_ready = 1'b0;
      rsp_valid = 1'b1; rsp_rdata = 16'h0042;
      tick(1);
      rsp_valid = 1'b0;
      n_cmp++; if (arm_data_out !== 16'h0042) begin n_err++; $display("FAIL rm_rd_data: got %h want 0042", arm_data_out); end
      arm_cs = 1'b1; arm_rd = 1'b1;
      tick(3);
   endtask

   initial begin
      test_reset();
      test_page_then_read();
      test_write_stall();
      test_abort();
      test_timeout();
      test_proto_err();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
